// File: rtl/boot_pkg.sv
// Purpose:      shared types and constants for the boot-time memory writer.
// Latency:      n/a (declarations only).
// Backpressure: n/a.
package boot_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int unsigned WORD_BYTES = 4;

  // Low address bits that must be zero for a word-aligned byte address.
  localparam logic [31:0] ALIGN_MASK = 32'(WORD_BYTES - 1);

  // One buffered write: address in the upper half, data in the lower half.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_ent_t;

  localparam int ENT_W = $bits(wr_ent_t);

  function automatic logic addr_misaligned(input logic [31:0] addr);
    return (addr & ALIGN_MASK) != 32'd0;
  endfunction

  // The last legal word starts at mem_bytes - WORD_BYTES.
  function automatic logic addr_out_of_range(input logic [31:0] addr,
                                             input logic [31:0] mem_bytes);
    return addr > (mem_bytes - 32'(WORD_BYTES));
  endfunction

endpackage

// File: rtl/boot_wr_fifo.sv
// Purpose:      synchronous write buffer holding {address, data} entries.
// Latency:      a push is visible at the head on the next cycle.
// Backpressure: full/empty/count come from registered state; push while full
//               and pop while empty are ignored.
// Ports: clk, rst_n (sync, active-low); push/wr_dat enqueue; pop dequeues;
//        rd_dat is the head entry; full, empty, count report occupancy.
module boot_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_dat,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_dat  = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so the pointers wrap without explicit compare.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing reads it while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_dat;
  end

endmodule

// File: rtl/boot_mem_writer.sv
// Purpose:      buffers parsed boot-image word writes, drives them to main
//               memory, then releases the CPU with the start PC.
// Latency:      a write accepted in cycle N requests memory at N+1 earliest.
// Backpressure: in_ready drops when the buffer is full (registered count) and
//               after load_done; memory side is req/ack, 1 write/cycle max.
// Ports: in_* parser write stream; entry_* S7 entry PC; load_done end of load;
//        mem_* memory write port; cpu_run/pc_start core release;
//        word_count and sticky err_* status.
module boot_mem_writer
  import boot_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] MEM_BYTES  = 32'h0001_0000,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_address,
  input  logic [31:0] in_data,
  input  logic        entry_valid,
  input  logic [31:0] entry_address,
  input  logic        load_done,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data,
  output logic        cpu_run,
  output logic [31:0] pc_start,
  output logic [15:0] word_count,
  output logic        err_align,
  output logic        err_range,
  output logic        err_late
);

  localparam int CW = ((FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1) + 1;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [15:0] wc_q, wc_d;
  logic        err_align_q, err_align_d;
  logic        err_range_q, err_range_d;
  logic        err_late_q, err_late_d;

  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  wr_ent_t       wr_ent, head;
  logic          accept, bad_align, bad_range, push, pop, drained;

  assign wr_ent    = {in_address, in_data};
  assign bad_align = addr_misaligned(in_address);
  assign bad_range = addr_out_of_range(in_address, MEM_BYTES);
  assign accept    = in_valid && in_ready;
  // Dropped writes still complete the handshake but never take a slot.
  assign push      = accept && !bad_align && !bad_range;

  // Held low during reset so an in-flight request is never acked then.
  assign mem_req     = rst_n && !fifo_empty;
  assign pop         = mem_req && mem_ack;
  assign mem_address = mem_req ? head.addr : 32'd0;
  assign mem_data    = mem_req ? head.data : 32'd0;

  // True when the buffer is empty after this cycle: either already empty, or
  // the last entry is being acked now. Lets cpu_run follow the final ack by
  // one cycle.
  assign drained = fifo_empty || ((fifo_count == CW'(1)) && pop);

  boot_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push),
    .wr_dat (wr_ent),
    .pop    (pop),
    .rd_dat (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    cpu_run  = 1'b0;
    unique case (state_q)
      LOAD: begin
        in_ready = rst_n && !fifo_full;
        if (load_done) state_d = DRAIN;
      end
      DRAIN: begin
        if (drained) state_d = DONE;
      end
      DONE: begin
        cpu_run = 1'b1;
      end
      default: state_d = LOAD;
    endcase
  end

  always_comb begin
    pc_d        = pc_q;
    wc_d        = wc_q;
    err_align_d = err_align_q | (accept & bad_align);
    err_range_d = err_range_q | (accept & bad_range);
    err_late_d  = err_late_q | (in_valid & (state_q != LOAD));
    // Once the core is running its start PC must not move.
    if (entry_valid && (state_q != DONE)) pc_d = entry_address;
    if (pop && (wc_q != 16'hFFFF)) wc_d = wc_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      pc_q        <= RESET_PC;
      wc_q        <= 16'd0;
      err_align_q <= 1'b0;
      err_range_q <= 1'b0;
      err_late_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      wc_q        <= wc_d;
      err_align_q <= err_align_d;
      err_range_q <= err_range_d;
      err_late_q  <= err_late_d;
    end
  end

  assign pc_start   = pc_q;
  assign word_count = wc_q;
  assign err_align  = err_align_q;
  assign err_range  = err_range_q;
  assign err_late   = err_late_q;

endmodule

// File: tb/tb_boot_mem_writer.sv
// Purpose:      directed self-checking bench for boot_mem_writer.
// Latency:      n/a.
// Backpressure: n/a.
module tb_boot_mem_writer;

  localparam logic [31:0] RST_PC = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_address, in_data;
  logic        entry_valid;
  logic [31:0] entry_address;
  logic        load_done;
  logic        mem_req, mem_ack;
  logic [31:0] mem_address, mem_data;
  logic        cpu_run;
  logic [31:0] pc_start;
  logic [15:0] word_count;
  logic        err_align, err_range, err_late;

  boot_mem_writer #(
    .FIFO_DEPTH (4),
    .MEM_BYTES  (32'h0001_0000),
    .RESET_PC   (RST_PC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_address    (in_address),
    .in_data       (in_data),
    .entry_valid   (entry_valid),
    .entry_address (entry_address),
    .load_done     (load_done),
    .mem_req       (mem_req),
    .mem_ack       (mem_ack),
    .mem_address   (mem_address),
    .mem_data      (mem_data),
    .cpu_run       (cpu_run),
    .pc_start      (pc_start),
    .word_count    (word_count),
    .err_align     (err_align),
    .err_range     (err_range),
    .err_late      (err_late)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Writes offered to the DUT and the writes expected on the memory port.
  logic [31:0] wa [8];
  logic [31:0] wd [8];
  logic [31:0] ea [8];
  logic [31:0] ed [8];
  int n_wr, n_exp, acc_idx, pop_idx;
  bit pend_acc, pend_pop;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle at the falling edge: retire what the last rising edge took,
  // drive the next offered write, check the memory port against the
  // expected order, and note what the coming rising edge will take.
  task automatic step(input logic ack);
    @(negedge clk);
    if (pend_acc) acc_idx++;
    if (pend_pop) pop_idx++;
    if (acc_idx < n_wr) begin
      in_valid   = 1'b1;
      in_address = wa[acc_idx];
      in_data    = wd[acc_idx];
    end else begin
      in_valid = 1'b0;
    end
    mem_ack = ack;
    if (mem_req) begin
      if (pop_idx < n_exp) begin
        check("ord_addr", mem_address, ea[pop_idx]);
        check("ord_data", mem_data, ed[pop_idx]);
      end else begin
        check("extra_req", 32'(mem_req), 32'd0);
      end
    end
    pend_acc = in_valid && in_ready;
    pend_pop = mem_req && mem_ack;
  endtask

  task automatic reset_assert(input int cycles);
    rst_n         = 1'b0;
    in_valid      = 1'b0;
    in_address    = 32'd0;
    in_data       = 32'd0;
    entry_valid   = 1'b0;
    entry_address = 32'd0;
    load_done     = 1'b0;
    mem_ack       = 1'b0;
    for (int i = 0; i < cycles; i++) @(negedge clk);
  endtask

  task automatic release_rst();
    rst_n    = 1'b1;
    acc_idx  = 0;
    pop_idx  = 0;
    pend_acc = 1'b0;
    pend_pop = 1'b0;
    n_wr     = 0;
    n_exp    = 0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    check({tag, "_mem_addr"}, mem_address, 32'd0);
    check({tag, "_mem_data"}, mem_data, 32'd0);
    check({tag, "_cpu_run"}, 32'(cpu_run), 32'd0);
    check({tag, "_pc_start"}, pc_start, RST_PC);
    check({tag, "_wcount"}, 32'(word_count), 32'd0);
    check({tag, "_err_align"}, 32'(err_align), 32'd0);
    check({tag, "_err_range"}, 32'(err_range), 32'd0);
    check({tag, "_err_late"}, 32'(err_late), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  initial begin
    // ---- reset values, then three in-order writes with ack tied high
    reset_assert(2);
    check_reset("rst0");
    release_rst();
    wa[0] = 32'h0; wd[0] = 32'h1111_1111;
    wa[1] = 32'h4; wd[1] = 32'h2222_2222;
    wa[2] = 32'h8; wd[2] = 32'h3333_3333;
    for (int i = 0; i < 3; i++) begin ea[i] = wa[i]; ed[i] = wd[i]; end
    n_wr = 3; n_exp = 3;
    step(1'b1);
    check("t1_lat_none", 32'(mem_req), 32'd0);
    step(1'b1);
    check("t1_lat_req", 32'(mem_req), 32'd1);
    step(1'b1);
    step(1'b1);
    check("t1_all_acc", acc_idx, 3);
    load_done = 1'b1;
    for (int i = 0; i < 20 && !cpu_run; i++) step(1'b1);
    check("t1_cpu_run", 32'(cpu_run), 32'd1);
    check("t1_pops", pop_idx, 3);
    check("t1_wcount", 32'(word_count), 32'd3);
    check("t1_pc", pc_start, RST_PC);
    check("t1_errs", {29'd0, err_align, err_range, err_late}, 32'd0);

    // ---- backpressure: ack low for 10 cycles while 6 writes are offered
    reset_assert(1);
    release_rst();
    for (int i = 0; i < 6; i++) begin
      wa[i] = 32'h100 + 32'(4 * i);
      wd[i] = 32'hA000_0000 + 32'(i);
      ea[i] = wa[i]; ed[i] = wd[i];
    end
    n_wr = 6; n_exp = 6;
    for (int i = 0; i < 10; i++) step(1'b0);
    check("t2_acc_full", acc_idx, 4);
    check("t2_rdy_full", 32'(in_ready), 32'd0);
    check("t2_req_held", 32'(mem_req), 32'd1);
    check("t2_wc_held", 32'(word_count), 32'd0);
    for (int i = 0; i < 12; i++) step(1'b1);
    check("t2_acc_all", acc_idx, 6);
    check("t2_pops", pop_idx, 6);
    check("t2_wcount", 32'(word_count), 32'd6);
    check("t2_req_idle", 32'(mem_req), 32'd0);

    // ---- filtering: misaligned, out of range, and the last legal word
    reset_assert(1);
    release_rst();
    wa[0] = 32'h0000_0006; wd[0] = 32'hDEAD_0006;
    wa[1] = 32'h0001_0000; wd[1] = 32'hDEAD_1000;
    wa[2] = 32'h0000_FFFC; wd[2] = 32'hBEEF_FFFC;
    ea[0] = wa[2]; ed[0] = wd[2];
    n_wr = 3; n_exp = 1;
    step(1'b1);
    step(1'b1);
    check("t3_align_set", 32'(err_align), 32'd1);
    check("t3_range_clr", 32'(err_range), 32'd0);
    check("t3_no_req_a", 32'(mem_req), 32'd0);
    step(1'b1);
    check("t3_range_set", 32'(err_range), 32'd1);
    check("t3_no_req_r", 32'(mem_req), 32'd0);
    check("t3_wc_zero", 32'(word_count), 32'd0);
    step(1'b1);
    check("t3_edge_req", 32'(mem_req), 32'd1);
    step(1'b1);
    check("t3_wcount", 32'(word_count), 32'd1);
    check("t3_acc_all", acc_idx, 3);
    check("t3_req_idle", 32'(mem_req), 32'd0);

    // ---- entry address, late write, both error flags, frozen PC
    reset_assert(1);
    release_rst();
    wa[0] = 32'h0001_0001; wd[0] = 32'h0BAD_0BAD;
    n_wr = 1; n_exp = 0;
    step(1'b0);
    entry_valid = 1'b1; entry_address = 32'h0000_0100;
    step(1'b0);
    entry_valid = 1'b0;
    check("t4_both_align", 32'(err_align), 32'd1);
    check("t4_both_range", 32'(err_range), 32'd1);
    check("t4_pc_latched", pc_start, 32'h0000_0100);
    check("t4_rdy_load", 32'(in_ready), 32'd1);
    load_done = 1'b1;
    step(1'b0);
    check("t4_rdy_drain", 32'(in_ready), 32'd0);
    check("t4_late_clr", 32'(err_late), 32'd0);
    check("t4_run_drain", 32'(cpu_run), 32'd0);
    in_valid = 1'b1; in_address = 32'h0000_0200; in_data = 32'h5A5A_5A5A;
    step(1'b0);
    check("t4_late_set", 32'(err_late), 32'd1);
    check("t4_run_done", 32'(cpu_run), 32'd1);
    check("t4_pc_run", pc_start, 32'h0000_0100);
    check("t4_no_req", 32'(mem_req), 32'd0);
    entry_valid = 1'b1; entry_address = 32'h0000_0200;
    step(1'b0);
    entry_valid = 1'b0;
    step(1'b0);
    check("t4_pc_frozen", pc_start, 32'h0000_0100);
    check("t4_wc_zero", 32'(word_count), 32'd0);

    // ---- load_done with the second write in the same cycle, random acks
    reset_assert(1);
    release_rst();
    wa[0] = 32'h20; wd[0] = 32'hC0DE_0001;
    wa[1] = 32'h24; wd[1] = 32'hC0DE_0002;
    for (int i = 0; i < 2; i++) begin ea[i] = wa[i]; ed[i] = wd[i]; end
    n_wr = 2; n_exp = 2;
    step(1'b0);
    step(1'b0);
    load_done = 1'b1;
    step(1'b0);
    check("t5_same_cyc_acc", acc_idx, 2);
    check("t5_rdy_drain", 32'(in_ready), 32'd0);
    check("t5_run_low", 32'(cpu_run), 32'd0);
    for (int i = 0; i < 40 && !cpu_run; i++) begin
      step((i < 30) ? 1'($urandom_range(0, 1)) : 1'b1);
      check("t5_run_vs_ack", 32'(cpu_run), 32'(pop_idx == 2));
    end
    check("t5_run_high", 32'(cpu_run), 32'd1);
    check("t5_pops", pop_idx, 2);
    check("t5_wcount", 32'(word_count), 32'd2);

    // ---- reset mid-drain with a request pending, then a fresh load
    reset_assert(1);
    release_rst();
    wa[0] = 32'h30; wd[0] = 32'h0000_0030;
    wa[1] = 32'h33; wd[1] = 32'h0000_0033;
    wa[2] = 32'h34; wd[2] = 32'h0000_0034;
    ea[0] = wa[0]; ed[0] = wd[0];
    ea[1] = wa[2]; ed[1] = wd[2];
    n_wr = 3; n_exp = 2;
    for (int i = 0; i < 4; i++) step(1'b0);
    load_done = 1'b1;
    step(1'b0);
    check("t6_req_pend", 32'(mem_req), 32'd1);
    check("t6_pend_addr", mem_address, 32'h30);
    check("t6_align_pre", 32'(err_align), 32'd1);
    reset_assert(0);
    mem_ack = 1'b1;
    @(negedge clk);
    check_reset("t6_rst");
    release_rst();
    @(negedge clk);
    check("t6_fifo_empty", 32'(mem_req), 32'd0);
    wa[0] = 32'h40; wd[0] = 32'h5555_AAAA;
    ea[0] = wa[0]; ed[0] = wd[0];
    n_wr = 1; n_exp = 1;
    step(1'b1);
    step(1'b1);
    load_done = 1'b1;
    for (int i = 0; i < 20 && !cpu_run; i++) step(1'b1);
    check("t6_run", 32'(cpu_run), 32'd1);
    check("t6_pops", pop_idx, 1);
    check("t6_wcount", 32'(word_count), 32'd1);
    check("t6_pc", pc_start, RST_PC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
